multiport_reg_file: RTL and testbench

MULTIPORT_REG_FILE -- requirements
Module: multiport_reg_file

---
 rtl/multiport_reg_file.sv | 127 ++++++++++++
 tb/tb_multiport_reg_file.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiport_reg_file.sv
// Multi-ported register file with a pending-write scoreboard and a zero-sweep
// that runs after reset or on request.
//   clk, rst              : clock and synchronous active-high reset
//   clr_req               : restart the zero-sweep (accepted only when ready)
//   init_busy             : high while the zero-sweep runs
//   wr_en/wr_addr/wr_data : NUM_WR packed write ports, port 0 in the LSBs
//   rsv_en/rsv_addr       : mark a destination register as pending
//   rd_addr               : NUM_RD packed read addresses
//   rd_data/rd_pend       : combinational read data and pending flag per lane
module multiport_reg_file #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_req,
  output logic                       init_busy,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_pend
);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cnt, cnt_nxt;
  logic [DATA_W-1:0]   mem [NUM_REGS];
  logic [NUM_REGS-1:0] pend;
  logic [ADDR_W-1:0]   rd_a;

  // State register; init_busy is registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      cnt       <= '0;
      init_busy <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      init_busy <= (state_nxt == ST_INIT);
    end
  end

  // Next-state: sweep every register once, then serve accesses
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_INIT: begin
        cnt_nxt = ADDR_W'(cnt + 1'b1);
        if (cnt == ADDR_W'(NUM_REGS - 1)) state_nxt = ST_READY;
      end
      ST_READY: begin
        if (clr_req) begin
          state_nxt = ST_INIT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Storage: sweep writes zero; later ports overwrite earlier ones on a clash
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        mem[cnt] <= '0;
      end else begin
        for (int p = 0; p < int'(NUM_WR); p++) begin
          if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] != '0))
            mem[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Scoreboard: writes clear, reserve is applied last so it wins a tie
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else if (state == ST_READY) begin
      if (clr_req) begin
        pend <= '0;
      end else begin
        for (int p = 0; p < int'(NUM_WR); p++) begin
          if (wr_en[p]) pend[wr_addr[p*ADDR_W +: ADDR_W]] <= 1'b0;
        end
        if (rsv_en && (rsv_addr != '0)) pend[rsv_addr] <= 1'b1;
      end
    end
  end

  // Read lanes: register 0 and the sweep read as zero/not pending
  always_comb begin
    rd_data = '0;
    rd_pend = '0;
    rd_a    = '0;
    for (int i = 0; i < int'(NUM_RD); i++) begin
      rd_a = rd_addr[i*ADDR_W +: ADDR_W];
      if ((state == ST_READY) && (rd_a != '0)) begin
        rd_data[i*DATA_W +: DATA_W] = mem[rd_a];
        rd_pend[i]                  = pend[rd_a];
        if (BYPASS != 0) begin
          for (int p = 0; p < int'(NUM_WR); p++) begin
            if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] == rd_a)) begin
              rd_data[i*DATA_W +: DATA_W] = wr_data[p*DATA_W +: DATA_W];
              rd_pend[i]                  = 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multiport_reg_file.sv
module tb_multiport_reg_file;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst, clr_req, rsv_en;
  logic [1:0]      wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [2*DW-1:0] wr_data;
  logic [AW-1:0]   rsv_addr;
  logic [2*AW-1:0] rd_addr;
  logic [2*DW-1:0] rd_data, rd_data_nb;
  logic [1:0]      rd_pend, rd_pend_nb;
  logic            init_busy, init_busy_nb;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        nb;
    logic [1:0]  lane;
    logic [31:0] data;
    logic        pend;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  multiport_reg_file #(.DATA_W(DW), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .init_busy(init_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend)
  );

  multiport_reg_file #(.DATA_W(DW), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .clr_req(clr_req), .init_busy(init_busy_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_pend(rd_pend_nb)
  );

  task automatic idle();
    rst = 1'b0; clr_req = 1'b0; rsv_en = 1'b0; rsv_addr = '0;
    wr_en = '0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic wr(input int port, input int a, input logic [31:0] d);
    wr_en[port] = 1'b1;
    wr_addr[port*AW +: AW] = AW'(a);
    wr_data[port*DW +: DW] = d;
  endtask

  task automatic rd(input int lane, input int a);
    rd_addr[lane*AW +: AW] = AW'(a);
  endtask

  // Expectation for both DUTs (same value) or per DUT
  task automatic expect_rd(input bit nb, input int lane, input logic [31:0] d, input logic p);
    sbq.push_back({nb, 2'(lane), d, p});
  endtask

  task automatic expect_both(input int lane, input logic [31:0] d, input logic p);
    expect_rd(1'b0, lane, d, p);
    expect_rd(1'b1, lane, d, p);
  endtask

  task automatic test_reset();
    int n;
    exp_t e;
    logic [31:0] gd;
    logic gp;
    idle(); rd_addr = '0;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b1; wr(0, 5, 32'hFFFF_FFFF); rsv_en = 1'b1; rsv_addr = 5'd3; clr_req = 1'b1;
    next_cycle();
    n = 0;
    while (init_busy === 1'b1 && n < 100) begin
      wr(0, (n > 0) ? n - 1 : 1, 32'hBAD0_0000 | 32'(n));
      wr(1, n / 2, 32'hC0DE_0000 | 32'(n));
      rsv_en = 1'b1; rsv_addr = AW'(n / 2 + 1); clr_req = 1'b1;
      rd(0, (n > 0) ? n - 1 : 1); rd(1, n / 2);
      #2;
      checks++;
      if (rd_data !== '0 || rd_pend !== '0 || rd_data_nb !== '0 || rd_pend_nb !== '0) begin
        errors++;
        $display("FAIL sweep_gating cyc%0d: got data=%h pend=%b, expected all zero", n, rd_data, rd_pend);
      end
      n++;
      next_cycle();
    end
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL reset_busy_cycles: got %0d, expected 32", n);
    end
    checks++;
    if (init_busy_nb !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_nb: got %b, expected 0", init_busy_nb);
    end
    for (int a = 0; a < 32; a += 2) begin
      rd(0, a); rd(1, a + 1);
      expect_both(0, 32'h0, 1'b0);
      expect_both(1, 32'h0, 1'b0);
      #2;
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        gd = e.nb ? rd_data_nb[e.lane*DW +: DW] : rd_data[e.lane*DW +: DW];
        gp = e.nb ? rd_pend_nb[e.lane] : rd_pend[e.lane];
        checks++;
        if (gd !== e.data || gp !== e.pend) begin
          errors++;
          $display("FAIL post_sweep_zero x%0d nb=%0d lane%0d: got data=%h pend=%b, expected data=%h pend=%b",
                   a + e.lane, e.nb, e.lane, gd, gp, e.data, e.pend);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    logic [31:0] gd;
    logic gp;
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin
          wr(0, 5, 32'hDEAD_BEEF); wr(1, 0, 32'h1234);
          rd(0, 0); rd(1, 0);
          expect_both(0, 32'h0, 1'b0); expect_both(1, 32'h0, 1'b0);
        end
        1: begin
          rd(0, 5); rd(1, 5);
          expect_both(0, 32'hDEAD_BEEF, 1'b0); expect_both(1, 32'hDEAD_BEEF, 1'b0);
        end
        default: begin
          rd(0, 0); rd(1, 5);
          expect_both(0, 32'h0, 1'b0); expect_both(1, 32'hDEAD_BEEF, 1'b0);
        end
      endcase
      #2;
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        gd = e.nb ? rd_data_nb[e.lane*DW +: DW] : rd_data[e.lane*DW +: DW];
        gp = e.nb ? rd_pend_nb[e.lane] : rd_pend[e.lane];
        checks++;
        if (gd !== e.data || gp !== e.pend) begin
          errors++;
          $display("FAIL write_read c%0d nb=%0d lane%0d: got data=%h pend=%b, expected data=%h pend=%b",
                   c, e.nb, e.lane, gd, gp, e.data, e.pend);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    logic [31:0] gd;
    logic gp;
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin
          wr(0, 7, 32'hA5A5_A5A5); rd(0, 7); rd(1, 5);
          expect_rd(1'b0, 0, 32'hA5A5_A5A5, 1'b0);
          expect_rd(1'b1, 0, 32'h0, 1'b0);
          expect_both(1, 32'hDEAD_BEEF, 1'b0);
        end
        1: begin
          wr(0, 7, 32'h11); wr(1, 7, 32'h22); rd(0, 7); rd(1, 7);
          expect_rd(1'b0, 0, 32'h22, 1'b0); expect_rd(1'b0, 1, 32'h22, 1'b0);
          expect_rd(1'b1, 0, 32'hA5A5_A5A5, 1'b0); expect_rd(1'b1, 1, 32'hA5A5_A5A5, 1'b0);
        end
        default: begin
          rd(0, 7); rd(1, 7);
          expect_both(0, 32'h22, 1'b0); expect_both(1, 32'h22, 1'b0);
        end
      endcase
      #2;
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        gd = e.nb ? rd_data_nb[e.lane*DW +: DW] : rd_data[e.lane*DW +: DW];
        gp = e.nb ? rd_pend_nb[e.lane] : rd_pend[e.lane];
        checks++;
        if (gd !== e.data || gp !== e.pend) begin
          errors++;
          $display("FAIL bypass c%0d nb=%0d lane%0d: got data=%h pend=%b, expected data=%h pend=%b",
                   c, e.nb, e.lane, gd, gp, e.data, e.pend);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_dual_write();
    exp_t e;
    logic [31:0] gd;
    logic gp;
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: begin
          wr(0, 9, 32'h1); wr(1, 9, 32'h2); rd(0, 9); rd(1, 5);
          expect_rd(1'b0, 0, 32'h2, 1'b0); expect_rd(1'b1, 0, 32'h0, 1'b0);
          expect_both(1, 32'hDEAD_BEEF, 1'b0);
        end
        1: begin
          rd(0, 9); rd(1, 9);
          expect_both(0, 32'h2, 1'b0); expect_both(1, 32'h2, 1'b0);
        end
        2: begin
          wr(0, 10, 32'h0000_AAAA); wr(1, 31, 32'hFFFF_BBBB); rd(0, 9); rd(1, 9);
          expect_both(0, 32'h2, 1'b0); expect_both(1, 32'h2, 1'b0);
        end
        default: begin
          rd(0, 10); rd(1, 31);
          expect_both(0, 32'h0000_AAAA, 1'b0); expect_both(1, 32'hFFFF_BBBB, 1'b0);
        end
      endcase
      #2;
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        gd = e.nb ? rd_data_nb[e.lane*DW +: DW] : rd_data[e.lane*DW +: DW];
        gp = e.nb ? rd_pend_nb[e.lane] : rd_pend[e.lane];
        checks++;
        if (gd !== e.data || gp !== e.pend) begin
          errors++;
          $display("FAIL dual_write c%0d nb=%0d lane%0d: got data=%h pend=%b, expected data=%h pend=%b",
                   c, e.nb, e.lane, gd, gp, e.data, e.pend);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_scoreboard();
    exp_t e;
    logic [31:0] gd;
    logic gp;
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: begin
          rsv_en = 1'b1; rsv_addr = 5'd3; rd(0, 3); rd(1, 4);
          expect_both(0, 32'h0, 1'b0); expect_both(1, 32'h0, 1'b0);
        end
        1: begin
          rd(0, 3); rd(1, 4);
          expect_both(0, 32'h0, 1'b1); expect_both(1, 32'h0, 1'b0);
        end
        2: begin
          wr(1, 3, 32'h33); rd(0, 3); rd(1, 4);
          expect_rd(1'b0, 0, 32'h33, 1'b0); expect_rd(1'b1, 0, 32'h0, 1'b1);
          expect_both(1, 32'h0, 1'b0);
        end
        3: begin
          rsv_en = 1'b1; rsv_addr = 5'd3; wr(0, 3, 32'h44); rd(0, 3); rd(1, 4);
          expect_rd(1'b0, 0, 32'h44, 1'b0); expect_rd(1'b1, 0, 32'h33, 1'b0);
          expect_both(1, 32'h0, 1'b0);
        end
        4: begin
          rsv_en = 1'b1; rsv_addr = 5'd0; rd(0, 3); rd(1, 0);
          expect_both(0, 32'h44, 1'b1); expect_both(1, 32'h0, 1'b0);
        end
        default: begin
          rd(0, 3); rd(1, 0);
          expect_both(0, 32'h44, 1'b1); expect_both(1, 32'h0, 1'b0);
        end
      endcase
      #2;
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        gd = e.nb ? rd_data_nb[e.lane*DW +: DW] : rd_data[e.lane*DW +: DW];
        gp = e.nb ? rd_pend_nb[e.lane] : rd_pend[e.lane];
        checks++;
        if (gd !== e.data || gp !== e.pend) begin
          errors++;
          $display("FAIL scoreboard c%0d nb=%0d lane%0d: got data=%h pend=%b, expected data=%h pend=%b",
                   c, e.nb, e.lane, gd, gp, e.data, e.pend);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_flush();
    int n;
    exp_t e;
    logic [31:0] gd;
    logic gp;
    for (int round = 0; round < 2; round++) begin
      if (round == 1) begin
        wr(0, 5, 32'hDEAD_BEEF); rsv_en = 1'b1; rsv_addr = 5'd3;
        next_cycle();
      end
      clr_req = 1'b1; rd(0, 5); rd(1, 3);
      expect_both(0, 32'hDEAD_BEEF, 1'b0);
      expect_both(1, (round == 0) ? 32'h44 : 32'h0, 1'b1);
      #2;
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        gd = e.nb ? rd_data_nb[e.lane*DW +: DW] : rd_data[e.lane*DW +: DW];
        gp = e.nb ? rd_pend_nb[e.lane] : rd_pend[e.lane];
        checks++;
        if (gd !== e.data || gp !== e.pend) begin
          errors++;
          $display("FAIL flush_pre r%0d nb=%0d lane%0d: got data=%h pend=%b, expected data=%h pend=%b",
                   round, e.nb, e.lane, gd, gp, e.data, e.pend);
        end
      end
      next_cycle();
      if (round == 1) begin
        // Let the sweep run partway, then reset to restart it
        for (int k = 0; k < 10; k++) begin
          checks++;
          if (init_busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_midsweep k%0d: got busy=%b, expected 1", k, init_busy);
          end
          next_cycle();
        end
        rst = 1'b1;
        next_cycle();
      end
      n = 0;
      while (init_busy === 1'b1 && n < 100) begin
        #2;
        checks++;
        if (rd_data !== '0 || rd_pend !== '0) begin
          errors++;
          $display("FAIL flush_gating r%0d cyc%0d: got data=%h pend=%b, expected zero", round, n, rd_data, rd_pend);
        end
        n++;
        next_cycle();
      end
      checks++;
      if (n !== 32) begin
        errors++;
        $display("FAIL flush_busy_cycles r%0d: got %0d, expected 32", round, n);
      end
      rd(0, 5); rd(1, 3);
      expect_both(0, 32'h0, 1'b0); expect_both(1, 32'h0, 1'b0);
      #2;
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        gd = e.nb ? rd_data_nb[e.lane*DW +: DW] : rd_data[e.lane*DW +: DW];
        gp = e.nb ? rd_pend_nb[e.lane] : rd_pend[e.lane];
        checks++;
        if (gd !== e.data || gp !== e.pend) begin
          errors++;
          $display("FAIL flush_post r%0d nb=%0d lane%0d: got data=%h pend=%b, expected data=%h pend=%b",
                   round, e.nb, e.lane, gd, gp, e.data, e.pend);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_dual_write();
    test_scoreboard();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
